queue_wait_lut: RTL and testbench
=================================

# queue_wait_lut

Parametrised wait-time lookup for the queue controller. It maps the live teller count (`tCount`) and the waiting-person count (`pCount`) to an estimated wait time shown on the display path. The table holds defaults computed at elaboration, can be rewritten at run time, flags out-of-range teller counts, and pulses a strobe when the displayed estimate changes. It sits between the people/teller counters and the display driver, and samples on the falling edge so that counters updated on the rising edge are stable when read.

## Interface
Parameters:
- `P_W`, default 3: width of `pCount`. The table has 2^P_W person rows per teller.
- `T_W`, default 2: width of `tCount`.
- `T_MAX`, default 3: highest valid teller count. Must satisfy 1 ≤ T_MAX ≤ 2^T_W − 1.
- `W_W`, default 5: width of `wTime`.
- `SVC`, default 3: service time per person, in wait units, used to compute the default table.

Ports:
- `clk`, in, 1: single clock. All state changes on the falling edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `pCount`, in, P_W: people currently waiting.
- `tCount`, in, T_W: tellers currently open. Valid range is 1..T_MAX.
- `cfg_we`, in, 1: table write strobe.
- `cfg_t`, in, T_W: teller count of the entry being written.
- `cfg_p`, in, P_W: person count of the entry being written.
- `cfg_data`, in, W_W: value to write.
- `wTime`, out, W_W: registered wait estimate.
- `wValid`, out, 1: `wTime` holds a lookup result.
- `wErr`, out, 1: `tCount` is out of range.
- `wUpd`, out, 1: one-cycle pulse when `wTime` changes.

## Operation
- Table has T_MAX × 2^P_W entries. Index = (t − 1) × 2^P_W + p.
- Default entry = min(ceil(p × SVC / t), 2^W_W − 1).
- On reset, every entry is reloaded with its default. Reset outputs: `wTime`=0, `wValid`=0, `wErr`=0, `wUpd`=0.
- Lookup on each falling edge:
  - If 1 ≤ `tCount` ≤ T_MAX: `wTime` ← entry, `wErr` ← 0.
  - Otherwise (including `tCount`=0): `wTime` ← all ones, `wErr` ← 1.
  - `wValid` ← 1.
- Change strobe:
  - `wUpd` ← 1 when the new `wTime` differs from the previous one, or on the first lookup after reset.
  - Otherwise `wUpd` ← 0.
- Table write, when `cfg_we`=1 on a falling edge:
  - Entry (`cfg_t`, `cfg_p`) ← `cfg_data`.
  - Ignored when `cfg_t`=0 or `cfg_t` > T_MAX.
- Simultaneous write and lookup of the same entry:
  - The lookup returns the old value (read-before-write).
  - The next falling edge returns the new value and pulses `wUpd` if the value differs.
- Reset mid-operation: all runtime writes are lost and the table returns to defaults. `wValid` drops to 0 immediately and asynchronously.

## Timing
- Lookup latency is one falling edge: inputs sampled at falling edge n are seen on `wTime`, `wErr` and `wUpd` right after edge n.
- Write latency is one falling edge. Visible to a lookup from edge n+1 onward.
- Back-to-back writes are allowed, one per cycle, with no stall and no handshake.
- After `rst` deasserts, `wValid` rises at the first falling edge.
- `wUpd` is never high for two consecutive cycles unless `wTime` changes on each of them.

## Configuration
- `QUEUE_LUT_CFG_WR_EN` defined:
  - Table is registers and the write port is active.
  - Reset reloads defaults.
- `QUEUE_LUT_CFG_WR_EN` undefined:
  - Table is a constant ROM of the defaults.
  - `cfg_*` ports stay present but are ignored.
  - Lookup, error and strobe behaviour are identical.

## Structure
- Shared package `queue_pkg` holds:
  - Constants: default widths, `T_MAX`, `SVC`.
  - Function `default_wtime(t, p)`: ceil-divide with saturation.
  - Index function `lut_index(t, p)`.
- One sub-module, `queue_wait_table`: table storage with write port and registered-free read. It holds the only `ifdef` on `QUEUE_LUT_CFG_WR_EN`.
- Top level holds the range check, output registers and change detector.

## Test plan
All scenarios use default parameters.
- Reset, then `tCount`=1, `pCount`=3 → first falling edge: `wTime`=9, `wValid`=1, `wUpd`=1, `wErr`=0.
- Step through (2,3), (3,7), (1,7) → `wTime` = 5, 7, 21. `wUpd` pulses on each step. Hold (1,7) → `wUpd`=0.
- `tCount`=0, then `tCount`=3→… use an out-of-range value (`tCount`=0) → `wTime`=31, `wErr`=1. Return to (1,3) → `wTime`=9, `wErr`=0.
- With the macro defined, write `cfg_t`=2, `cfg_p`=3, `cfg_data`=17 while looking up (2,3):
  - Same edge: `wTime`=5.
  - Next edge: `wTime`=17, `wUpd`=1.
  - Write with `cfg_t`=0 → no entry changes.
- Assert `rst` mid-run after the write → outputs go to 0 asynchronously. After release, (2,3) → `wTime`=5 (default restored).
- With the macro undefined, repeat the write scenario → `wTime` stays 5.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared constants and table helpers for the queue wait-time lookup.
// Default parameter values live here so the top and table agree.
package queue_pkg;

  localparam int P_W_DEF   = 3;
  localparam int T_W_DEF   = 2;
  localparam int T_MAX_DEF = 3;
  localparam int W_W_DEF   = 5;
  localparam int SVC_DEF   = 3;

  // Default wait: ceil(p * svc / t), clipped to the largest value w_w bits can show.
  // A zero teller count has no meaningful estimate and returns the saturated value.
  function automatic int default_wtime(input int t, input int p, input int svc, input int w_w);
    int num;
    int sat;
    int q;
    num = p * svc;
    sat = (32'sd1 <<< w_w) - 32'sd1;
    if (t <= 32'sd0) begin
      q = sat;
    end else begin
      q = (num + t - 32'sd1) / t;
    end
    if (q > sat) begin
      q = sat;
    end else begin
      q = q;
    end
    return q;
  endfunction

  // Flat table index: teller rows are 1-based, person columns 0-based.
  function automatic int lut_index(input int t, input int p, input int p_w);
    return (t - 32'sd1) * (32'sd1 <<< p_w) + p;
  endfunction

endpackage

// File: rtl/queue_wait_table.sv
// Wait-time table storage with a combinational read port.
// QUEUE_LUT_CFG_WR_EN defined   : registered table, write port active, reset reloads defaults.
// QUEUE_LUT_CFG_WR_EN undefined : constant ROM of defaults, write port ignored.
module queue_wait_table
  import queue_pkg::*;
#(
  parameter int P_W   = P_W_DEF,
  parameter int T_W   = T_W_DEF,
  parameter int T_MAX = T_MAX_DEF,
  parameter int W_W   = W_W_DEF,
  parameter int SVC   = SVC_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [T_W-1:0] cfg_t,
  input  logic [P_W-1:0] cfg_p,
  input  logic [W_W-1:0] cfg_data,
  input  logic [T_W-1:0] rd_t,
  input  logic [P_W-1:0] rd_p,
  output logic [W_W-1:0] rd_data
);

  localparam int ROWS  = 2 ** P_W;
  localparam int DEPTH = T_MAX * ROWS;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [T_W-1:0] T_LO = T_W'(1);
  localparam logic [T_W-1:0] T_HI = T_W'(T_MAX);

  logic [W_W-1:0]   entry_s [DEPTH];
  logic             rd_ok_s;
  logic [IDX_W-1:0] rd_idx_s;

  // Out-of-range teller counts yield a meaningless index; rd_ok_s masks them.
  assign rd_ok_s  = (rd_t >= T_LO) && (rd_t <= T_HI);
  assign rd_idx_s = IDX_W'(lut_index(int'(rd_t), int'(rd_p), P_W));

  // Combinational read; an invalid teller count reads as zero (top overrides it anyway).
  always_comb begin
    rd_data = {W_W{1'b0}};
    if (rd_ok_s) begin
      rd_data = entry_s[rd_idx_s];
    end else begin
      rd_data = {W_W{1'b0}};
    end
  end

`ifdef QUEUE_LUT_CFG_WR_EN

  logic [W_W-1:0]   entry_r [DEPTH];
  logic             wr_ok_s;
  logic [IDX_W-1:0] wr_idx_s;

  assign wr_ok_s  = cfg_we && (cfg_t >= T_LO) && (cfg_t <= T_HI);
  assign wr_idx_s = IDX_W'(lut_index(int'(cfg_t), int'(cfg_p), P_W));

  // Table registers: reset reloads defaults, falling-edge write of one entry otherwise.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= W_W'(default_wtime(i / ROWS + 1, i % ROWS, SVC, W_W));
      end
    end else if (wr_ok_s) begin
      entry_r[wr_idx_s] <= cfg_data;
    end else begin
      entry_r <= entry_r;
    end
  end

  // Expose the register contents to the shared read mux.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_s[i] = entry_r[i];
    end
  end

`else

  logic cfg_unused_s;

  // Constant ROM of the default estimates; folds to wiring.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_s[i] = W_W'(default_wtime(i / ROWS + 1, i % ROWS, SVC, W_W));
    end
  end

  // Write port and clocking are intentionally inert in ROM form.
  assign cfg_unused_s = ^{clk, rst, cfg_we, cfg_t, cfg_p, cfg_data};

`endif

endmodule

// File: rtl/queue_wait_lut.sv
// Queue wait-time lookup: maps (tCount, pCount) to a registered wait estimate,
// flags out-of-range teller counts and strobes wUpd when the estimate changes.
// All state moves on the falling clock edge so rising-edge counters are stable.
// Optional runtime table writes: define QUEUE_LUT_CFG_WR_EN.
module queue_wait_lut
  import queue_pkg::*;
#(
  parameter int P_W   = P_W_DEF,
  parameter int T_W   = T_W_DEF,
  parameter int T_MAX = T_MAX_DEF,
  parameter int W_W   = W_W_DEF,
  parameter int SVC   = SVC_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [P_W-1:0] pCount,
  input  logic [T_W-1:0] tCount,
  input  logic           cfg_we,
  input  logic [T_W-1:0] cfg_t,
  input  logic [P_W-1:0] cfg_p,
  input  logic [W_W-1:0] cfg_data,
  output logic [W_W-1:0] wTime,
  output logic           wValid,
  output logic           wErr,
  output logic           wUpd
);

  localparam logic [T_W-1:0] T_LO = T_W'(1);
  localparam logic [T_W-1:0] T_HI = T_W'(T_MAX);

  logic [W_W-1:0] rd_data_s;
  logic           in_range_s;
  logic [W_W-1:0] wtime_nxt_s;

  logic [W_W-1:0] wtime_r;
  logic           wvalid_r;
  logic           werr_r;
  logic           wupd_r;

  queue_wait_table #(
    .P_W   (P_W),
    .T_W   (T_W),
    .T_MAX (T_MAX),
    .W_W   (W_W),
    .SVC   (SVC)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_t    (cfg_t),
    .cfg_p    (cfg_p),
    .cfg_data (cfg_data),
    .rd_t     (tCount),
    .rd_p     (pCount),
    .rd_data  (rd_data_s)
  );

  assign in_range_s = (tCount >= T_LO) && (tCount <= T_HI);

  // Select the table entry, or the saturated error value for a bad teller count.
  always_comb begin
    wtime_nxt_s = {W_W{1'b1}};
    if (in_range_s) begin
      wtime_nxt_s = rd_data_s;
    end else begin
      wtime_nxt_s = {W_W{1'b1}};
    end
  end

  // Output registers and change detector; the first lookup after reset always strobes.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      wtime_r  <= {W_W{1'b0}};
      wvalid_r <= 1'b0;
      werr_r   <= 1'b0;
      wupd_r   <= 1'b0;
    end else begin
      wtime_r  <= wtime_nxt_s;
      wvalid_r <= 1'b1;
      werr_r   <= ~in_range_s;
      wupd_r   <= (wtime_nxt_s != wtime_r) || ~wvalid_r;
    end
  end

  assign wTime  = wtime_r;
  assign wValid = wvalid_r;
  assign wErr   = werr_r;
  assign wUpd   = wupd_r;

endmodule

// File: tb/tb_queue_wait_lut.sv
// Directed bench for queue_wait_lut with a scoreboard of expected lookups.
// Expectations for runtime writes depend on QUEUE_LUT_CFG_WR_EN.
module tb_queue_wait_lut;

`ifdef QUEUE_LUT_CFG_WR_EN
  localparam bit WR = 1'b1;
`else
  localparam bit WR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] pCount;
  logic [1:0] tCount;
  logic       cfg_we;
  logic [1:0] cfg_t;
  logic [2:0] cfg_p;
  logic [4:0] cfg_data;
  logic [4:0] wTime;
  logic       wValid;
  logic       wErr;
  logic       wUpd;

  typedef struct {
    logic [4:0] t;
    logic       err;
    logic       upd;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic [4:0] last_t   = 5'd0;
  logic       first    = 1'b1;

  queue_wait_lut dut (
    .clk      (clk),
    .rst      (rst),
    .pCount   (pCount),
    .tCount   (tCount),
    .cfg_we   (cfg_we),
    .cfg_t    (cfg_t),
    .cfg_p    (cfg_p),
    .cfg_data (cfg_data),
    .wTime    (wTime),
    .wValid   (wValid),
    .wErr     (wErr),
    .wUpd     (wUpd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one lookup (optionally with a write) after a rising edge, then check
  // just after the following falling edge.
  task automatic step(input logic [1:0] t, input logic [2:0] p,
                      input logic we, input logic [1:0] ct, input logic [2:0] cp,
                      input logic [4:0] cd, input logic [4:0] et, input logic ee,
                      input string tag);
    exp_t e;
    exp_t got;
    @(posedge clk);
    #1;
    tCount   = t;
    pCount   = p;
    cfg_we   = we;
    cfg_t    = ct;
    cfg_p    = cp;
    cfg_data = cd;
    e.t   = et;
    e.err = ee;
    e.upd = first || (et != last_t);
    e.tag = tag;
    first  = 1'b0;
    last_t = et;
    sb.push_back(e);
    @(negedge clk);
    #1;
    cfg_we = 1'b0;
    got = sb.pop_front();
    chk({got.tag, ".wTime"},  wTime,         got.t);
    chk({got.tag, ".wErr"},   {4'd0, wErr},  {4'd0, got.err});
    chk({got.tag, ".wUpd"},   {4'd0, wUpd},  {4'd0, got.upd});
    chk({got.tag, ".wValid"}, {4'd0, wValid}, 5'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".wTime"},  wTime,          5'd0);
    chk({tag, ".wValid"}, {4'd0, wValid}, 5'd0);
    chk({tag, ".wErr"},   {4'd0, wErr},   5'd0);
    chk({tag, ".wUpd"},   {4'd0, wUpd},   5'd0);
  endtask

  initial begin
    rst      = 1'b1;
    pCount   = 3'd0;
    tCount   = 2'd0;
    cfg_we   = 1'b0;
    cfg_t    = 2'd0;
    cfg_p    = 3'd0;
    cfg_data = 5'd0;
    #1;
    chk_reset("rst0");
    @(negedge clk);
    #1;
    chk_reset("rst_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic lookups and change strobe
    step(2'd1, 3'd3, 1'b0, 2'd0, 3'd0, 5'd0, 5'd9,  1'b0, "t1p3_first");
    step(2'd2, 3'd3, 1'b0, 2'd0, 3'd0, 5'd0, 5'd5,  1'b0, "t2p3");
    step(2'd3, 3'd7, 1'b0, 2'd0, 3'd0, 5'd0, 5'd7,  1'b0, "t3p7");
    step(2'd1, 3'd7, 1'b0, 2'd0, 3'd0, 5'd0, 5'd21, 1'b0, "t1p7");
    step(2'd1, 3'd7, 1'b0, 2'd0, 3'd0, 5'd0, 5'd21, 1'b0, "t1p7_hold");
    step(2'd1, 3'd0, 1'b0, 2'd0, 3'd0, 5'd0, 5'd0,  1'b0, "t1p0");
    step(2'd3, 3'd1, 1'b0, 2'd0, 3'd0, 5'd0, 5'd1,  1'b0, "t3p1");

    // Out-of-range teller count
    step(2'd0, 3'd7, 1'b0, 2'd0, 3'd0, 5'd0, 5'd31, 1'b1, "t0p7");
    step(2'd0, 3'd3, 1'b0, 2'd0, 3'd0, 5'd0, 5'd31, 1'b1, "t0p3_hold");
    step(2'd1, 3'd3, 1'b0, 2'd0, 3'd0, 5'd0, 5'd9,  1'b0, "t1p3_back");
    step(2'd2, 3'd3, 1'b0, 2'd0, 3'd0, 5'd0, 5'd5,  1'b0, "t2p3_pre");

    // Write while looking up the same entry: old value first, new value next edge
    step(2'd2, 3'd3, 1'b1, 2'd2, 3'd3, 5'd17, 5'd5, 1'b0, "wr_same_edge");
    step(2'd2, 3'd3, 1'b0, 2'd0, 3'd0, 5'd0, WR ? 5'd17 : 5'd5, 1'b0, "wr_next_edge");

    // Invalid write target, then confirm neighbouring entries are untouched
    step(2'd2, 3'd3, 1'b1, 2'd0, 3'd3, 5'd1, WR ? 5'd17 : 5'd5, 1'b0, "wr_t0");
    step(2'd1, 3'd3, 1'b0, 2'd0, 3'd0, 5'd0, 5'd9, 1'b0, "after_t0_t1p3");
    step(2'd3, 3'd3, 1'b0, 2'd0, 3'd0, 5'd0, 5'd3, 1'b0, "after_t0_t3p3");

    // Back-to-back writes, including the highest valid teller row
    step(2'd1, 3'd0, 1'b1, 2'd3, 3'd7, 5'd2, 5'd0, 1'b0, "wr_b2b_a");
    step(2'd1, 3'd0, 1'b1, 2'd1, 3'd0, 5'd4, 5'd0, 1'b0, "wr_b2b_b");
    step(2'd3, 3'd7, 1'b0, 2'd0, 3'd0, 5'd0, WR ? 5'd2 : 5'd7, 1'b0, "rd_b2b_a");
    step(2'd1, 3'd0, 1'b0, 2'd0, 3'd0, 5'd0, WR ? 5'd4 : 5'd0, 1'b0, "rd_b2b_b");

    // Asynchronous reset mid-run wipes outputs and runtime writes
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("rst_mid");
    first = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2'd2, 3'd3, 1'b0, 2'd0, 3'd0, 5'd0, 5'd5, 1'b0, "post_rst_t2p3");
    step(2'd3, 3'd7, 1'b0, 2'd0, 3'd0, 5'd0, 5'd7, 1'b0, "post_rst_t3p7");
    step(2'd1, 3'd0, 1'b0, 2'd0, 3'd0, 5'd0, 5'd0, 1'b0, "post_rst_t1p0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
